ray_column_scheduler: RTL and testbench

//  Frame-level sequencer for the horizontal and vertical wall-intersection finders.
//  - Per frame: sweeps NUM_COLS screen columns and generates each ray angle.
//  - Per column: launches both finders together, collects both results, keeps the nearer hit.
//  - Hands one column record to the renderer over a valid/ready handshake.
//  - Sits between the frame/player-state logic and the two finder instances.

---
 rtl/raycast_pkg.sv | 32 +++
 rtl/ray_hit_select.sv | 44 ++++
 rtl/ray_column_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_ray_column_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raycast_pkg.sv
// Shared widths, angle constants and scheduler state encoding for the raycaster.
package raycast_pkg;

  localparam int COORD_W = 13;
  localparam int DX_W    = 14;
  localparam int ANGLE_W = 19;
  localparam int DEG_W   = 10;
  localparam int COL_W   = 10;
  localparam int DIST_W  = 28;

  // 360 degrees in 1/1024-degree units
  localparam logic [ANGLE_W-1:0] ANGLE_FULL  = 19'd368640;
  localparam logic [DIST_W-1:0]  DIST_NO_HIT = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_SELECT = 3'd3,
    S_OUTPUT = 3'd4
  } sched_state_t;

  // Modular add; valid while both operands are below ANGLE_FULL.
  function automatic logic [ANGLE_W-1:0] angle_add(input logic [ANGLE_W-1:0] ang,
                                                   input logic [ANGLE_W-1:0] step);
    logic [ANGLE_W:0] sum;
    sum = {1'b0, ang} + {1'b0, step};
    if (sum >= {1'b0, ANGLE_FULL}) sum = sum - {1'b0, ANGLE_FULL};
    return sum[ANGLE_W-1:0];
  endfunction

endpackage

// File: rtl/ray_hit_select.sv
// Combinational nearer-hit selection between the horizontal and vertical finder results.
module ray_hit_select
  import raycast_pkg::*;
(
  input  logic signed [COORD_W-1:0] player_x,
  input  logic signed [COORD_W-1:0] player_y,
  input  logic signed [COORD_W-1:0] h_wall_x,
  input  logic signed [COORD_W-1:0] h_wall_y,
  input  logic                      h_found,
  input  logic signed [COORD_W-1:0] v_wall_x,
  input  logic signed [COORD_W-1:0] v_wall_y,
  input  logic                      v_found,
  output logic [DIST_W-1:0]         h_dist_sq,
  output logic [DIST_W-1:0]         v_dist_sq,
  output logic                      v_wins,
  output logic                      hit,
  output logic signed [COORD_W-1:0] wall_x,
  output logic signed [COORD_W-1:0] wall_y
);

  logic signed [DX_W-1:0]   hdx, hdy, vdx, vdy;
  logic signed [DIST_W-1:0] hdx_e, hdy_e, vdx_e, vdy_e;

  // 14-bit differences cannot overflow for 13-bit signed operands
  assign hdx = DX_W'(h_wall_x) - DX_W'(player_x);
  assign hdy = DX_W'(h_wall_y) - DX_W'(player_y);
  assign vdx = DX_W'(v_wall_x) - DX_W'(player_x);
  assign vdy = DX_W'(v_wall_y) - DX_W'(player_y);

  assign hdx_e = DIST_W'(hdx);
  assign hdy_e = DIST_W'(hdy);
  assign vdx_e = DIST_W'(vdx);
  assign vdy_e = DIST_W'(vdy);

  assign h_dist_sq = $unsigned(hdx_e * hdx_e + hdy_e * hdy_e);
  assign v_dist_sq = $unsigned(vdx_e * vdx_e + vdy_e * vdy_e);

  // Ties go to the horizontal finder
  assign v_wins = v_found && (!h_found || (v_dist_sq < h_dist_sq));
  assign hit    = h_found || v_found;
  assign wall_x = v_wins ? v_wall_x : (h_found ? h_wall_x : '0);
  assign wall_y = v_wins ? v_wall_y : (h_found ? h_wall_y : '0);

endmodule

// File: rtl/ray_column_scheduler.sv
// Per-frame column sweep: launches both wall finders, keeps the nearer hit, streams records.
// Optional WAIT watchdog is enabled by defining RAYCAST_WATCHDOG_EN.
module ray_column_scheduler
  import raycast_pkg::*;
#(
  parameter int NUM_COLS        = 320,
  parameter int ANGLE_STEP      = 192,
  parameter int HALF_FOV        = 30720,
  parameter int WATCHDOG_CYCLES = 4096
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start_frame,
  input  logic signed [COORD_W-1:0] player_x,
  input  logic signed [COORD_W-1:0] player_y,
  input  logic [DEG_W-1:0]          player_angle_X,
  input  logic [DEG_W-1:0]          player_angle_Y,
  output logic [DEG_W-1:0]          alpha_X,
  output logic [DEG_W-1:0]          alpha_Y,
  output logic                      begin_calc,
  input  logic signed [COORD_W-1:0] h_wall_x,
  input  logic signed [COORD_W-1:0] h_wall_y,
  input  logic                      h_wall_found,
  input  logic                      h_end_calc,
  input  logic signed [COORD_W-1:0] v_wall_x,
  input  logic signed [COORD_W-1:0] v_wall_y,
  input  logic                      v_wall_found,
  input  logic                      v_end_calc,
  output logic                      col_valid,
  input  logic                      col_ready,
  output logic [COL_W-1:0]          col_index,
  output logic signed [COORD_W-1:0] col_wall_x,
  output logic signed [COORD_W-1:0] col_wall_y,
  output logic                      col_hit,
  output logic                      col_vert,
  output logic [DIST_W-1:0]         col_dist_sq,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      timeout_err,
  output logic [2:0]                state_dbg
);

  localparam logic [ANGLE_W:0]   HALF_FOV_V = (ANGLE_W + 1)'(HALF_FOV);
  localparam logic [ANGLE_W-1:0] STEP_V     = ANGLE_W'(ANGLE_STEP);
  localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(NUM_COLS - 1);

  // Handshake: a record transfers on a rising clock edge where col_valid && col_ready;
  // col_valid never drops and the col_* fields never change until that transfer.

  sched_state_t state, state_nxt;

  logic signed [COORD_W-1:0] px_r, py_r;
  logic [ANGLE_W-1:0]        ang_r, init_ang;
  logic [ANGLE_W:0]          player_ang;
  logic [COL_W-1:0]          col_r;
  logic                      h_done, v_done;
  logic signed [COORD_W-1:0] hx_r, hy_r, vx_r, vy_r;
  logic                      hf_r, vf_r;
  logic                      wd_expired;
  logic                      both_done;

  logic [DIST_W-1:0]         sel_h_dist, sel_v_dist;
  logic                      sel_v_wins, sel_hit;
  logic signed [COORD_W-1:0] sel_x, sel_y;

  assign player_ang = {player_angle_X, player_angle_Y};
  assign init_ang   = (player_ang >= HALF_FOV_V)
                    ? ANGLE_W'(player_ang - HALF_FOV_V)
                    : ANGLE_W'(player_ang + {1'b0, ANGLE_FULL} - HALF_FOV_V);

  assign both_done = (h_done || h_end_calc) && (v_done || v_end_calc);

  ray_hit_select u_hit_select (
    .player_x  (px_r),
    .player_y  (py_r),
    .h_wall_x  (hx_r),
    .h_wall_y  (hy_r),
    .h_found   (hf_r),
    .v_wall_x  (vx_r),
    .v_wall_y  (vy_r),
    .v_found   (vf_r),
    .h_dist_sq (sel_h_dist),
    .v_dist_sq (sel_v_dist),
    .v_wins    (sel_v_wins),
    .hit       (sel_hit),
    .wall_x    (sel_x),
    .wall_y    (sel_y)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_frame) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (both_done || wd_expired) state_nxt = S_SELECT;
      S_SELECT: state_nxt = S_OUTPUT;
      S_OUTPUT: if (col_ready) state_nxt = (col_r == LAST_COL) ? S_IDLE : S_LAUNCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      px_r        <= '0;
      py_r        <= '0;
      ang_r       <= '0;
      col_r       <= '0;
      h_done      <= 1'b0;
      v_done      <= 1'b0;
      hx_r        <= '0;
      hy_r        <= '0;
      vx_r        <= '0;
      vy_r        <= '0;
      hf_r        <= 1'b0;
      vf_r        <= 1'b0;
      col_wall_x  <= '0;
      col_wall_y  <= '0;
      col_hit     <= 1'b0;
      col_vert    <= 1'b0;
      col_dist_sq <= DIST_NO_HIT;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: if (start_frame) begin
          px_r  <= player_x;
          py_r  <= player_y;
          ang_r <= init_ang;
          col_r <= '0;
        end
        S_LAUNCH: begin
          h_done <= 1'b0;
          v_done <= 1'b0;
          hf_r   <= 1'b0;
          vf_r   <= 1'b0;
        end
        S_WAIT: begin
          // A finder left undone at watchdog expiry keeps found=0 from LAUNCH
          if (h_end_calc && !h_done) begin
            h_done <= 1'b1;
            hx_r   <= h_wall_x;
            hy_r   <= h_wall_y;
            hf_r   <= h_wall_found;
          end
          if (v_end_calc && !v_done) begin
            v_done <= 1'b1;
            vx_r   <= v_wall_x;
            vy_r   <= v_wall_y;
            vf_r   <= v_wall_found;
          end
        end
        S_SELECT: begin
          col_wall_x  <= sel_x;
          col_wall_y  <= sel_y;
          col_hit     <= sel_hit;
          col_vert    <= sel_v_wins;
          col_dist_sq <= !sel_hit ? DIST_NO_HIT : (sel_v_wins ? sel_v_dist : sel_h_dist);
        end
        S_OUTPUT: if (col_ready) begin
          if (col_r == LAST_COL) begin
            frame_done <= 1'b1;
          end else begin
            col_r <= col_r + 1'b1;
            ang_r <= angle_add(ang_r, STEP_V);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RAYCAST_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_r;

  assign wd_expired  = (state == S_WAIT) && (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1));
  assign timeout_err = timeout_r;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt    <= '0;
      timeout_r <= 1'b0;
    end else begin
      if (state == S_LAUNCH)    wd_cnt <= '0;
      else if (state == S_WAIT) wd_cnt <= wd_cnt + 1'b1;
      if (state == S_IDLE && start_frame) timeout_r <= 1'b0;
      else if (wd_expired && !both_done)  timeout_r <= 1'b1;
    end
  end
`else
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign alpha_X    = DEG_W'(ang_r[ANGLE_W-1:10]);
  assign alpha_Y    = ang_r[9:0];
  assign begin_calc = (state == S_LAUNCH);
  assign col_valid  = (state == S_OUTPUT);
  assign col_index  = col_r;
  assign busy       = (state != S_IDLE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_ray_column_scheduler.sv
// Self-checking bench for ray_column_scheduler: directed scenarios plus randomized frames.
module tb_ray_column_scheduler;

  localparam int NUM_COLS   = 4;
  localparam int ANGLE_STEP = 200;
  localparam int HALF_FOV   = 30720;
  localparam int WD_CYC     = 64;
  localparam int FULL       = 368640;
  localparam logic [27:0] NO_HIT = 28'hFFFFFFF;

  logic               clock, reset, start_frame;
  logic signed [12:0] player_x, player_y;
  logic [9:0]         player_angle_X, player_angle_Y, alpha_X, alpha_Y;
  logic               begin_calc;
  logic signed [12:0] h_wall_x, h_wall_y, v_wall_x, v_wall_y;
  logic               h_wall_found, h_end_calc, v_wall_found, v_end_calc;
  logic               col_valid, col_ready;
  logic [9:0]         col_index;
  logic signed [12:0] col_wall_x, col_wall_y;
  logic               col_hit, col_vert;
  logic [27:0]        col_dist_sq;
  logic               busy, frame_done, timeout_err;
  logic [2:0]         state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [65:0] exp_q[$];
  int cur_px, cur_py, cur_pang;

  ray_column_scheduler #(
    .NUM_COLS(NUM_COLS), .ANGLE_STEP(ANGLE_STEP), .HALF_FOV(HALF_FOV), .WATCHDOG_CYCLES(WD_CYC)
  ) dut (
    .clock(clock), .reset(reset), .start_frame(start_frame),
    .player_x(player_x), .player_y(player_y),
    .player_angle_X(player_angle_X), .player_angle_Y(player_angle_Y),
    .alpha_X(alpha_X), .alpha_Y(alpha_Y), .begin_calc(begin_calc),
    .h_wall_x(h_wall_x), .h_wall_y(h_wall_y), .h_wall_found(h_wall_found), .h_end_calc(h_end_calc),
    .v_wall_x(v_wall_x), .v_wall_y(v_wall_y), .v_wall_found(v_wall_found), .v_end_calc(v_end_calc),
    .col_valid(col_valid), .col_ready(col_ready), .col_index(col_index),
    .col_wall_x(col_wall_x), .col_wall_y(col_wall_y), .col_hit(col_hit), .col_vert(col_vert),
    .col_dist_sq(col_dist_sq), .busy(busy), .frame_done(frame_done),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_begin_calc"}, begin_calc, 0);
    check({pfx, "_col_valid"}, col_valid, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_frame_done"}, frame_done, 0);
    check({pfx, "_timeout_err"}, timeout_err, 0);
    check({pfx, "_alpha_x"}, alpha_X, 0);
    check({pfx, "_alpha_y"}, alpha_Y, 0);
    check({pfx, "_col_index"}, col_index, 0);
    check({pfx, "_col_hit"}, col_hit, 0);
    check({pfx, "_col_vert"}, col_vert, 0);
    check({pfx, "_wall"}, {col_wall_x, col_wall_y}, 0);
    check({pfx, "_dist"}, col_dist_sq, NO_HIT);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check_idle_outputs("rst_async");
    @(negedge clock);
    reset = 1'b0;
    check_idle_outputs("rst_release");
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_alpha(input int pang, input int col);
    int a;
    a = (pang - HALF_FOV + col * ANGLE_STEP) % FULL;
    if (a < 0) a += FULL;
    return a;
  endfunction

  function automatic int ref_d2(input int wx, input int wy);
    return (wx - cur_px) * (wx - cur_px) + (wy - cur_py) * (wy - cur_py);
  endfunction

  function automatic int rnd_coord();
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  // ---------------- drivers ----------------
  task automatic start(input int px, input int py, input int ax, input int ay);
    @(negedge clock);
    start_frame = 1'b1;
    player_x = 13'(px); player_y = 13'(py);
    player_angle_X = 10'(ax); player_angle_Y = 10'(ay);
    cur_px = px; cur_py = py; cur_pang = ax * 1024 + ay;
    @(negedge clock);
    start_frame = 1'b0;
    // Junk after the accepted start must never be latched
    player_x = 13'(rnd_coord()); player_y = 13'(rnd_coord());
    player_angle_X = 10'($urandom_range(0, 359)); player_angle_Y = 10'($urandom_range(0, 1023));
    check("busy_after_start", busy, 1);
  endtask

  task automatic run_column(input int col, input int hd, input int vd, input logic hf, input logic vf,
                            input int hx, input int hy, input int vx, input int vy, input int stall);
    int waitc, a, dh, dv, last_k;
    logic spur, is_last;
    logic [65:0] exp_rec, got_rec, held;
    is_last = (col == NUM_COLS - 1);
    waitc = 0;
    while (begin_calc !== 1'b1 && waitc < 40) begin
      @(negedge clock);
      waitc++;
    end
    check("launch_seen", begin_calc, 1);
    a = ref_alpha(cur_pang, col);
    check("alpha_x", alpha_X, a / 1024);
    check("alpha_y", alpha_Y, a % 1024);

    dh = ref_d2(hx, hy);
    dv = ref_d2(vx, vy);
    if (hf && (!vf || dh <= dv)) exp_rec = {10'(col), 1'b1, 1'b0, 13'(hx), 13'(hy), 28'(dh)};
    else if (vf)                 exp_rec = {10'(col), 1'b1, 1'b1, 13'(vx), 13'(vy), 28'(dv)};
    else                         exp_rec = {10'(col), 1'b0, 1'b0, 13'd0, 13'd0, NO_HIT};
    exp_q.push_back(exp_rec);

    spur = ($urandom_range(0, 3) == 0);
    last_k = (hd > vd) ? hd : vd;
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clock);
      if (k == 1) check("launch_one_cycle", begin_calc, 0);
      start_frame  = spur && (k == 1);
      col_ready    = 1'($urandom_range(0, 1));
      h_end_calc   = (k == hd);
      v_end_calc   = (k == vd);
      h_wall_found = (k == hd) ? hf : 1'($urandom_range(0, 1));
      v_wall_found = (k == vd) ? vf : 1'($urandom_range(0, 1));
      h_wall_x = (k == hd) ? 13'(hx) : 13'(rnd_coord());
      h_wall_y = (k == hd) ? 13'(hy) : 13'(rnd_coord());
      v_wall_x = (k == vd) ? 13'(vx) : 13'(rnd_coord());
      v_wall_y = (k == vd) ? 13'(vy) : 13'(rnd_coord());
    end
    @(negedge clock);
    h_end_calc = 1'b0; v_end_calc = 1'b0; start_frame = 1'b0; col_ready = 1'b0;
    check("select_not_valid", col_valid, 0);
    @(negedge clock);
    check("valid_latency", col_valid, 1);
    check("alpha_stable", {alpha_X, alpha_Y}, {10'(a / 1024), 10'(a % 1024)});
    got_rec = {col_index, col_hit, col_vert, col_wall_x, col_wall_y, col_dist_sq};
    exp_rec = exp_q.pop_front();
    check("rec_index", got_rec[65:56], exp_rec[65:56]);
    check("rec_hit", got_rec[55], exp_rec[55]);
    check("rec_vert", got_rec[54], exp_rec[54]);
    check("rec_wall_x", got_rec[53:41], exp_rec[53:41]);
    check("rec_wall_y", got_rec[40:28], exp_rec[40:28]);
    check("rec_dist", got_rec[27:0], exp_rec[27:0]);
    check("timeout_clear", timeout_err, 0);

    held = got_rec;
    for (int s = 0; s < stall; s++) begin
      // Stray finder pulses outside WAIT must change nothing
      h_end_calc = (s == 0); v_end_calc = (s == 0);
      h_wall_found = 1'b1; v_wall_found = 1'b1;
      h_wall_x = 13'(rnd_coord()); v_wall_y = 13'(rnd_coord());
      @(negedge clock);
      check("stall_valid", {col_valid, begin_calc, frame_done}, 3'b100);
      check("stall_stable", {col_index, col_hit, col_vert, col_wall_x, col_wall_y, col_dist_sq}, held);
    end
    h_end_calc = 1'b0; v_end_calc = 1'b0;
    col_ready = 1'b1;
    @(negedge clock);
    col_ready = 1'b0;
    check("frame_done_at_accept", frame_done, is_last);
    check("busy_after_accept", busy, !is_last);
    if (is_last) begin
      @(negedge clock);
      check("frame_done_single", {frame_done, begin_calc, col_valid}, 0);
    end
  endtask

  task automatic run_random_frame();
    int hd, vd;
    start(rnd_coord(), rnd_coord(), int'($urandom_range(0, 359)), int'($urandom_range(0, 1023)));
    for (int c = 0; c < NUM_COLS; c++) begin
      hd = int'($urandom_range(1, 12));
      vd = ($urandom_range(0, 3) == 0) ? hd : int'($urandom_range(1, 12));
      run_column(c, hd, vd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord(), int'($urandom_range(0, 4)));
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int waitc;
    reset = 1'b1; start_frame = 1'b0; col_ready = 1'b0;
    player_x = '0; player_y = '0; player_angle_X = '0; player_angle_Y = '0;
    h_wall_x = '0; h_wall_y = '0; h_wall_found = 1'b0; h_end_calc = 1'b0;
    v_wall_x = '0; v_wall_y = '0; v_wall_found = 1'b0; v_end_calc = 1'b0;
    repeat (2) @(negedge clock);
    do_reset();

    // Angle init, selection, tie, skewed no-hit, backpressure
    start(100, 100, 0, 0);
    check("t1_alpha0_x", alpha_X, 330);
    check("t1_alpha0_y", alpha_Y, 0);
    run_column(0, 2, 3, 1, 1, 164, 100, 100, 300, 10);
    run_column(1, 4, 4, 1, 1, 164, 100, 100, 164, 0);
    run_column(2, 3, 9, 0, 0, 55, 66, 77, 88, 1);
    run_column(3, 5, 2, 1, 1, 500, 500, 90, 90, 10);

    // Wrap through 0 degrees
    start(0, 0, 29, 900);
    check("t2_alpha0_x", alpha_X, 359);
    check("t2_alpha0_y", alpha_Y, 900);
    run_column(0, 1, 1, 1, 0, 10, 20, 30, 40, 0);
    check("t2_alpha1", {alpha_X, alpha_Y}, {10'd0, 10'd76});
    run_column(1, 2, 1, 0, 1, -10, -20, -4096, 4095, 2);
    run_column(2, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    run_column(3, 7, 3, 1, 1, -300, 12, 301, -12, 3);

    // Reset in the middle of WAIT, then a fresh frame
    start(5, 5, 180, 0);
    waitc = 0;
    while (begin_calc !== 1'b1 && waitc < 40) begin
      @(negedge clock);
      waitc++;
    end
    @(negedge clock);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("post_reset_quiet", {begin_calc, col_valid, frame_done, busy}, 0);
    end
    start(-50, 70, 45, 512);
    for (int c = 0; c < NUM_COLS; c++)
      run_column(c, c + 1, 4 - c, 1, 1, 100 * c, 7, -100, 60 * c, c);

    for (int f = 0; f < 6; f++) run_random_frame();

`ifdef RAYCAST_WATCHDOG_EN
    start(0, 0, 90, 0);
    waitc = 0;
    while (begin_calc !== 1'b1 && waitc < 40) begin
      @(negedge clock);
      waitc++;
    end
    @(negedge clock);
    h_end_calc = 1'b1; h_wall_found = 1'b1; h_wall_x = 13'd10; h_wall_y = 13'd0;
    @(negedge clock);
    h_end_calc = 1'b0;
    waitc = 0;
    while (col_valid !== 1'b1 && waitc < WD_CYC + 20) begin
      @(negedge clock);
      waitc++;
    end
    check("wd_valid", col_valid, 1);
    check("wd_timeout_err", timeout_err, 1);
    check("wd_record", {col_hit, col_vert, col_dist_sq}, {1'b1, 1'b0, 28'd100});
    col_ready = 1'b1;
    @(negedge clock);
    col_ready = 1'b0;
    check("wd_timeout_sticky", timeout_err, 1);
    do_reset();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
